// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes LSB-first into words, writes from addr 0.
// Ports: clk, resetn, load_en, rx_valid/rx_data/rx_break in; mem_we/mem_addr/mem_wdata, write_done, word_count, err_timeout, err_overflow out.
module uart_word_loader #(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TERM_COUNT     = 2,
  localparam int WORD_W        = 8 * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_timeout,
  output logic              err_overflow
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RUN_W = $clog2(TERM_COUNT + 1);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  idle_q, idle_d;
  logic [RUN_W-1:0]  run_q, run_d, run_nx;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              ovf_q, ovf_d;
  logic              load_en_q;
  logic              rise;

  assign rise = load_en && !load_en_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      idle_q    <= '0;
      run_q     <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovf_q     <= 1'b0;
      load_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      run_q     <= run_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      load_en_q <= load_en;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    run_d   = run_q;
    run_nx  = '0;
    word_d  = word_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    ovf_d   = ovf_q;
    // Dropping load_en abandons the partial word but keeps status visible.
    if (!load_en) begin
      state_d = IDLE;
      idx_d   = '0;
      idle_d  = '0;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = COLLECT;
            idx_d   = '0;
            idle_d  = '0;
            run_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        COLLECT: begin
          if (rx_break) begin
            idx_d  = '0;
            idle_d = '0;
            run_d  = '0;
          end else if (rx_valid) begin
            idle_d = '0;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
              if (idx_q == IDX_W'(i)) word_d[i*8 +: 8] = rx_data;
            end
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              // Memory full: drop the word instead of wrapping.
              if (cnt_q == CNT_W'(DEPTH)) begin
                state_d = DONE;
                done_d  = 1'b1;
                ovf_d   = 1'b1;
              end else begin
                state_d = WRITE;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (idx_q != '0) begin
            if (idle_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              idx_d  = '0;
              idle_d = '0;
              tmo_d  = 1'b1;
            end else begin
              idle_d = idle_q + TMO_W'(1);
            end
          end
        end
        WRITE: begin
          cnt_d  = cnt_q + CNT_W'(1);
          run_nx = (&word_q) ? run_q + RUN_W'(1) : '0;
          if (rx_break) run_nx = '0;
          run_d = run_nx;
          if (run_nx == RUN_W'(TERM_COUNT)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
            // A byte arriving now starts the next word.
            if (rx_valid && !rx_break) begin
              word_d[7:0] = rx_data;
              idx_d       = IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_we       = (state_q == WRITE);
  assign mem_addr     = cnt_q[ADDR_W-1:0];
  assign mem_wdata    = word_q;
  assign write_done   = done_q;
  assign word_count   = cnt_q;
  assign err_timeout  = tmo_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: directed and random loads against a word-list model.
// Small DEPTH and TIMEOUT so overflow and timeout are reachable quickly.
module tb_uart_word_loader;

  localparam int BPW   = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int TERM  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic load_en = 1'b0;
  logic rx_valid = 1'b0;
  logic rx_break = 1'b0;
  logic [7:0] rx_data = '0;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic write_done;
  logic [AW:0] word_count;
  logic err_timeout;
  logic err_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0]   words[$];
  logic [31:0]   act_d[$];
  logic [AW-1:0] act_a[$];
  int            act_c[$];
  int            lastc[$];

  uart_word_loader #(
    .BYTES_PER_WORD(BPW),
    .ADDR_W(AW),
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .TERM_COUNT(TERM)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .load_en(load_en),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_break(rx_break),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .write_done(write_done),
    .word_count(word_count),
    .err_timeout(err_timeout),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      act_d.push_back(mem_wdata);
      act_a.push_back(mem_addr);
      act_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < BPW; i++) begin
      idle(gap);
      send_byte(w[i*8 +: 8]);
    end
    lastc.push_back(cyc);
  endtask

  task automatic pulse_break();
    rx_break = 1'b1;
    @(posedge clk);
    #1;
    rx_break = 1'b0;
  endtask

  task automatic start_load();
    load_en = 1'b0;
    @(posedge clk);
    #1;
    load_en = 1'b1;
    @(posedge clk);
    #1;
    words.delete();
    act_d.delete();
    act_a.delete();
    act_c.delete();
    lastc.delete();
  endtask

  // Expected writes: words in order until TERM all-ones words in a row
  // end the load, or a word arrives with DEPTH words already stored.
  task automatic check_load(input string tag, input bit exp_tmo);
    logic [31:0] e[$];
    bit done = 1'b0;
    bit ovf = 1'b0;
    int run = 0;
    foreach (words[i]) begin
      if (done) break;
      if (e.size() == DEPTH) begin
        ovf  = 1'b1;
        done = 1'b1;
        break;
      end
      e.push_back(words[i]);
      run = (words[i] == 32'hFFFF_FFFF) ? run + 1 : 0;
      if (run == TERM) done = 1'b1;
    end
    idle(3);
    chk({tag, "_nwr"}, 64'(act_d.size()), 64'(e.size()));
    for (int k = 0; k < act_d.size() && k < e.size(); k++) begin
      chk({tag, "_addr"}, 64'(act_a[k]), 64'(k));
      chk({tag, "_data"}, 64'(act_d[k]), 64'(e[k]));
      chk({tag, "_lat"}, 64'(act_c[k]), 64'(lastc[k]));
    end
    chk({tag, "_cnt"}, 64'(word_count), 64'(e.size()));
    chk({tag, "_done"}, 64'(write_done), 64'(done));
    chk({tag, "_ovf"}, 64'(err_overflow), 64'(ovf));
    chk({tag, "_tmo"}, 64'(err_timeout), 64'(exp_tmo));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_done"}, 64'(write_done), 64'(0));
    chk({tag, "_cnt"}, 64'(word_count), 64'(0));
    chk({tag, "_tmo"}, 64'(err_timeout), 64'(0));
    chk({tag, "_ovf"}, 64'(err_overflow), 64'(0));
  endtask

  initial begin
    logic [31:0] w;
    int n;

    #3;
    chk_zero("reset");
    #4;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    start_load();
    words.push_back(32'hFD01_0113);
    words.push_back(32'h0281_2623);
    foreach (words[i]) send_word(words[i], 0);
    check_load("two_words", 1'b0);

    start_load();
    words.push_back(32'h0000_0093);
    words.push_back(32'hFFFF_FFFF);
    words.push_back(32'hFFFF_FFFF);
    words.push_back(32'h1234_5678);
    foreach (words[i]) send_word(words[i], 1);
    check_load("marker", 1'b0);

    start_load();
    words.push_back(32'hFFFF_FFFF);
    words.push_back(32'h0000_0013);
    words.push_back(32'hFFFF_FFFF);
    foreach (words[i]) send_word(words[i], 0);
    check_load("run_reset", 1'b0);

    start_load();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(TMO);
    chk("tmo_fire", 64'(err_timeout), 64'(1));
    words.push_back(32'h4433_2211);
    send_word(32'h4433_2211, 0);
    check_load("timeout", 1'b1);

    start_load();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(TMO - 1);
    chk("tmo_edge", 64'(err_timeout), 64'(0));
    send_byte(8'hCC);
    send_byte(8'hDD);
    lastc.push_back(cyc);
    words.push_back(32'hDDCC_BBAA);
    check_load("tmo_edge", 1'b0);

    start_load();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      words.push_back(w);
      send_word(w, 0);
    end
    check_load("overflow", 1'b0);

    start_load();
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_break();
    words.push_back(32'hCAFE_F00D);
    send_word(32'hCAFE_F00D, 0);
    check_load("brk", 1'b0);

    start_load();
    send_word(32'hFFFF_FFFF, 0);
    pulse_break();
    send_word(32'hFFFF_FFFF, 0);
    idle(3);
    chk("brk_run_done", 64'(write_done), 64'(0));
    chk("brk_run_cnt", 64'(word_count), 64'(2));

    start_load();
    send_word(32'h1111_2222, 0);
    send_byte(8'h77);
    send_byte(8'h88);
    load_en = 1'b0;
    idle(2);
    chk("drop_hold", 64'(word_count), 64'(1));
    start_load();
    chk("drop_clr", 64'(word_count), 64'(0));
    words.push_back(32'h5566_7788);
    send_word(32'h5566_7788, 0);
    check_load("drop", 1'b0);

    for (int l = 0; l < 6; l++) begin
      start_load();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        w = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        words.push_back(w);
        send_word(w, $urandom_range(0, 3));
      end
      check_load("rnd", 1'b0);
    end

    start_load();
    send_word(32'h0BAD_CAFE, 0);
    send_byte(8'h5A);
    send_byte(8'h6B);
    idle(1);
    chk("rst_pre", 64'(word_count), 64'(1));
    act_d.delete();
    act_a.delete();
    act_c.delete();
    resetn = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(6);
    chk("rst_nowr", 64'(act_d.size()), 64'(0));
    chk("rst_cnt", 64'(word_count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Parametrised UART-to-memory loader that sits between the UART receiver and the instruction memory in the wrapper.
- Assembles received bytes, least-significant byte first, into words of BYTES_PER_WORD bytes and writes them to consecutive addresses starting at 0.
- Adds three behaviours over the fixed 4-byte loader: an inter-byte timeout, overflow protection, and a configurable end-of-program marker that raises write_done.

Parameters:
- BYTES_PER_WORD, 4, bytes per word; WORD_W = 8*BYTES_PER_WORD.
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of writable words; must be <= 2^ADDR_W.
- TIMEOUT_CYCLES, 65535, maximum idle clk cycles allowed between bytes inside a partially assembled word.
- TERM_COUNT, 2, number of consecutive all-ones words that terminate loading.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- load_en  in  1  loader enable; a rising edge starts a new load
- rx_valid  in  1  one-cycle pulse, rx_data is valid
- rx_data  in  8  received byte
- rx_break  in  1  UART break detected
- mem_we  out  1  memory write strobe, one cycle
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  WORD_W  assembled word
- write_done  out  1  load complete; sticky
- word_count  out  ADDR_W+1  number of words written
- err_timeout  out  1  sticky; a partial word was discarded on timeout
- err_overflow  out  1  sticky; a word arrived beyond DEPTH

Behaviour:
- Reset (resetn low, asynchronous) drives every output to 0, state to IDLE, byte index to 0 and the all-ones run counter to 0.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - On rising load_en (low in the previous cycle, high now): clear word_count, mem_addr, write_done and both error flags, then go to COLLECT.
- COLLECT:
  - Each rx_valid stores rx_data into byte lane [idx], where lane 0 holds bits 7:0.
  - idx increments on each stored byte.
  - On the byte with idx = BYTES_PER_WORD-1, go to WRITE in the next cycle. mem_we is therefore high in the cycle after the final rx_valid (latency 1).
- WRITE (one cycle):
  - mem_we=1; mem_wdata = assembled word; mem_addr = word_count.
  - word_count increments at the end of the cycle.
  - If the word is all ones, the run counter increments; otherwise the run counter is cleared.
  - If the run reaches TERM_COUNT, go to DONE; otherwise return to COLLECT with idx=0.
  - Marker words are written to memory like any other word.
- Overflow:
  - A word completing while word_count = DEPTH is not written (mem_we stays 0).
  - err_overflow is set and the state goes to DONE.
- DONE:
  - write_done=1; rx_valid is ignored.
  - Leave only through a fresh rising load_en, which restarts at address 0.
- Timeout:
  - In COLLECT with idx != 0, an idle counter increments every cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES, the partial word is discarded, idx=0 and err_timeout=1. The state stays in COLLECT.
  - The counter clears on each rx_valid. It does not run while idx = 0.
- rx_break: discards any partial word (idx=0) with no error flag. The run counter is cleared.
- Simultaneous events:
  - rx_valid in the cycle the timeout fires: the byte wins and the counter clears.
  - rx_valid during WRITE: the byte is stored as lane 0 of the next word.
- load_en deasserted in any state:
  - Go to IDLE next cycle and abandon any partial word.
  - word_count, write_done and the error flags hold their values for software readback.
- rx_valid in IDLE is ignored.

Test Plan:
- Load with bytes 13,01,01,FD then 23,26,81,02 -> mem_we at addr 0 with FD010113, then addr 1 with 02812623, each one cycle after the last byte; word_count=2.
- Words 00000093, FFFFFFFF, FFFFFFFF -> three writes (addr 0..2), write_done=1 after the third; further bytes produce no mem_we.
- Words FFFFFFFF, 00000013, FFFFFFFF -> run counter resets, write_done stays 0, word_count=3.
- Bytes AA,BB then TIMEOUT_CYCLES idle cycles, then 11,22,33,44 -> err_timeout=1, single write of 44332211 at addr 0.
- Bench with DEPTH=4: send 5 non-marker words -> 4 writes, err_overflow=1, write_done=1, word_count=4, no fifth mem_we.
- Reset and abort cases:
  - resetn pulsed low after 2 bytes -> all outputs 0 immediately, no write.
  - load_en dropped mid-word then re-raised -> the next 4 bytes write at addr 0.
